// File: rtl/pipe_stage_bank.sv
// -----------------------------------------------------------------------------
// pipe_stage_bank
//   Elastic pipeline register bank carrying one packed payload through DEPTH
//   register stages with a valid/ready handshake, a global hold (hazard stall)
//   and a global flush. The low CTRL_W payload bits are control bits and are
//   forced to zero in every empty or squashed slot, so a bubble can never
//   write memory or the register file downstream.
//
// Optional feature macro: PIPE_PERF_EN
//   When defined, stall_cnt and flush_cnt are saturating performance counters.
//   When undefined, both outputs are tied to zero and no counter flops exist.
//
// Ports
//   clk        in   1               clock, rising edge
//   rst        in   1               synchronous reset, active high
//   in_valid   in   1               upstream slot valid
//   in_ready   out  1               bank accepts in_data this cycle (comb.)
//   in_data    in   WIDTH           upstream payload
//   hold       in   1               freeze all stages
//   flush      in   1               squash all stages and the incoming slot
//   out_valid  out  1               last stage valid
//   out_ready  in   1               downstream accepts
//   out_data   out  WIDTH           last-stage payload
//   occ        out  $clog2(DEPTH+1) number of valid stages (registered)
//   stall_cnt  out  CNT_W           stall cycles
//   flush_cnt  out  CNT_W           squashed valid slots
// -----------------------------------------------------------------------------
module pipe_stage_bank #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       hold,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    // Mask selecting the control bits; built bitwise so CTRL_W=0 and
    // CTRL_W=WIDTH need no special-case slicing.
    function automatic logic [WIDTH-1:0] ctrl_mask_f();
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (i < CTRL_W);
        end
        return m;
    endfunction

    localparam logic [WIDTH-1:0] CTRL_MASK = ctrl_mask_f();

    function automatic logic [OCC_W-1:0] popcount_f(input logic [DEPTH-1:0] vec);
        logic [OCC_W-1:0] c;
        c = {OCC_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            c = c + OCC_W'(vec[i]);
        end
        return c;
    endfunction

    logic [DEPTH-1:0] v_r;
    logic [DEPTH-1:0] v_nxt_s;
    logic [WIDTH-1:0] d_r     [DEPTH];
    logic [WIDTH-1:0] d_nxt_s [DEPTH];
    logic [DEPTH-1:0] rdy_s;
    logic [OCC_W-1:0] occ_r;

    // Ready chain from the output back to stage 0; a local carry keeps the
    // chain free of self-referencing vector reads.
    always_comb begin
        logic carry;
        rdy_s = {DEPTH{1'b0}};
        carry = out_ready & ~hold;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            carry    = (~v_r[k] | carry) & ~hold;
            rdy_s[k] = carry;
        end
    end

    // Next-state of every stage: flush squashes everything (even under hold),
    // otherwise each stage shifts forward when the stage after it is ready.
    always_comb begin
        v_nxt_s = v_r;
        for (int k = 0; k < DEPTH; k++) begin
            d_nxt_s[k] = d_r[k];
        end
        if (flush) begin
            v_nxt_s = {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                d_nxt_s[k] = d_r[k] & ~CTRL_MASK;
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy_s[k]) begin
                    v_nxt_s[k] = v_r[k-1];
                    d_nxt_s[k] = v_r[k-1] ? d_r[k-1] : (d_r[k-1] & ~CTRL_MASK);
                end else begin
                    v_nxt_s[k] = v_r[k];
                    d_nxt_s[k] = d_r[k];
                end
            end
            if (rdy_s[0]) begin
                v_nxt_s[0] = in_valid;
                d_nxt_s[0] = in_valid ? in_data : (in_data & ~CTRL_MASK);
            end else begin
                v_nxt_s[0] = v_r[0];
                d_nxt_s[0] = d_r[0];
            end
        end
    end

    // Stage registers and occupancy, occupancy tracked from the next valid vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r   <= {DEPTH{1'b0}};
            occ_r <= {OCC_W{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                d_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            v_r   <= v_nxt_s;
            occ_r <= popcount_f(v_nxt_s);
            for (int k = 0; k < DEPTH; k++) begin
                d_r[k] <= d_nxt_s[k];
            end
        end
    end

    assign in_ready  = rdy_s[0];
    assign out_valid = v_r[DEPTH-1];
    assign out_data  = d_r[DEPTH-1];
    assign occ       = occ_r;

`ifdef PIPE_PERF_EN
    localparam int               SUM_W   = CNT_W + OCC_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic [SUM_W-1:0] flush_sum_s;
    logic             stall_evt_s;

    // Squashed-slot total: valid stages plus the incoming slot if it was accepted.
    always_comb begin
        stall_evt_s = (v_r[DEPTH-1] & ~out_ready) | hold;
        flush_sum_s = SUM_W'(flush_cnt_r) + SUM_W'(popcount_f(v_r))
                    + SUM_W'(in_valid & rdy_s[0]);
    end

    // Saturating perf counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_evt_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush) begin
                flush_cnt_r <= (flush_sum_s > SUM_W'(CNT_MAX)) ? CNT_MAX
                                                               : flush_sum_s[CNT_W-1:0];
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_bank.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_bank
//   Directed bench for pipe_stage_bank. Two instances: dut_a (DEPTH=3,
//   CNT_W=16) and dut_b (DEPTH=2, CNT_W=4). Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_pipe_stage_bank;

`ifdef PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;

    // dut_a: DEPTH=3
    logic        a_rst, a_in_valid, a_in_ready, a_hold, a_flush, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_stall_cnt, a_flush_cnt;

    // dut_b: DEPTH=2, CNT_W=4
    logic        b_rst, b_in_valid, b_in_ready, b_hold, b_flush, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    pipe_stage_bank #(.WIDTH(32), .CTRL_W(8), .DEPTH(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .hold(a_hold), .flush(a_flush), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .occ(a_occ),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_stage_bank #(.WIDTH(32), .CTRL_W(8), .DEPTH(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .hold(b_hold), .flush(b_flush), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .occ(b_occ),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        tick(); tick();
        compared++; if (a_out_valid !== 1'b0) begin failed++; $display("FAIL rst_a_out_valid got %b want 0", a_out_valid); end
        compared++; if (a_out_data !== 32'h0) begin failed++; $display("FAIL rst_a_out_data got %h want 0", a_out_data); end
        compared++; if (a_occ !== 2'd0) begin failed++; $display("FAIL rst_a_occ got %0d want 0", a_occ); end
        compared++; if (a_in_ready !== 1'b1) begin failed++; $display("FAIL rst_a_in_ready got %b want 1", a_in_ready); end
        compared++; if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin failed++; $display("FAIL rst_a_cnt got %0d/%0d want 0/0", a_stall_cnt, a_flush_cnt); end
        compared++; if (b_out_valid !== 1'b0 || b_occ !== 2'd0) begin failed++; $display("FAIL rst_b_state got v=%b occ=%0d want 0/0", b_out_valid, b_occ); end
        a_rst = 1'b0; b_rst = 1'b0;
    endtask

    // DEPTH=3 streaming: A1..A5 in, A1..A3 out on cycles 3..5, occ steady 3.
    task automatic test_pipeline();
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'hA1 + i;
            tick();
            if (i >= 2) begin
                compared++; if (a_out_data !== 32'hA1 + (i - 2)) begin failed++; $display("FAIL pipe_data[%0d] got %h want %h", i, a_out_data, 32'hA1 + (i - 2)); end
                compared++; if (a_out_valid !== 1'b1 || a_occ !== 2'd3) begin failed++; $display("FAIL pipe_occ[%0d] got v=%b occ=%0d want 1/3", i, a_out_valid, a_occ); end
            end
        end
    endtask

    // Flush of a full bank with an incoming valid slot.
    task automatic test_flush();
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hA6;
        #1;
        compared++; if (a_in_ready !== 1'b1) begin failed++; $display("FAIL flush_in_ready got %b want 1", a_in_ready); end
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        compared++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin failed++; $display("FAIL flush_state got occ=%0d v=%b want 0/0", a_occ, a_out_valid); end
        compared++; if (a_out_data[7:0] !== 8'h00) begin failed++; $display("FAIL flush_ctrl got %h want 00", a_out_data[7:0]); end
        compared++; if (a_flush_cnt !== (PERF ? 16'd4 : 16'd0)) begin failed++; $display("FAIL flush_cnt got %0d want %0d", a_flush_cnt, PERF ? 4 : 0); end
        tick();
        compared++; if (a_out_valid !== 1'b0) begin failed++; $display("FAIL flush_drop got v=%b want 0", a_out_valid); end
    endtask

    // Five hold cycles mid-stream with out_ready=1.
    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1; a_in_data = 32'h5500_00B1 + i;
            tick();
        end
        a_hold = 1'b1; a_in_data = 32'h5500_00B4;
        for (int i = 0; i < 5; i++) begin
            #1;
            compared++; if (a_in_ready !== 1'b0) begin failed++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, a_in_ready); end
            tick();
            compared++; if (a_out_data !== 32'h5500_00B1 || a_out_valid !== 1'b1 || a_occ !== 2'd3) begin failed++; $display("FAIL hold_frozen[%0d] got %h v=%b occ=%0d", i, a_out_data, a_out_valid, a_occ); end
        end
        compared++; if (a_stall_cnt !== (PERF ? 16'd5 : 16'd0)) begin failed++; $display("FAIL hold_stall_cnt got %0d want %0d", a_stall_cnt, PERF ? 5 : 0); end
        a_hold = 1'b0;
        tick();
        compared++; if (a_out_data !== 32'h5500_00B2) begin failed++; $display("FAIL hold_resume got %h want 550000b2", a_out_data); end
    endtask

    // Flush+hold together at occ=2, then reset mid-stream.
    task automatic test_flush_hold_rst();
        a_in_valid = 1'b0;
        tick();
        compared++; if (a_occ !== 2'd2) begin failed++; $display("FAIL fh_pre_occ got %0d want 2", a_occ); end
        a_flush = 1'b1; a_hold = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hC0;
        tick();
        a_flush = 1'b0; a_hold = 1'b0;
        compared++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin failed++; $display("FAIL fh_state got occ=%0d v=%b want 0/0", a_occ, a_out_valid); end
        compared++; if (a_flush_cnt !== (PERF ? 16'd6 : 16'd0)) begin failed++; $display("FAIL fh_flush_cnt got %0d want %0d", a_flush_cnt, PERF ? 6 : 0); end
        for (int i = 0; i < 3; i++) begin
            a_in_data = 32'h7700_00C1 + i;
            tick();
        end
        compared++; if (a_out_data !== 32'h7700_00C1) begin failed++; $display("FAIL rst_pre_data got %h want 770000c1", a_out_data); end
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0; a_in_valid = 1'b0;
        compared++; if (a_out_data !== 32'h0 || a_occ !== 2'd0 || a_out_valid !== 1'b0) begin failed++; $display("FAIL rst_mid got %h occ=%0d v=%b", a_out_data, a_occ, a_out_valid); end
        compared++; if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin failed++; $display("FAIL rst_mid_cnt got %0d/%0d want 0/0", a_stall_cnt, a_flush_cnt); end
    endtask

    // DEPTH=2 backpressure and drain; bubble keeps upper bits, clears ctrl.
    task automatic test_backpressure();
        b_out_ready = 1'b0; b_in_valid = 1'b1;
        b_in_data = 32'hCAFE_0011; tick();
        b_in_data = 32'hBEEF_0022; tick();
        b_in_data = 32'hD00D_0033;
        #1;
        compared++; if (b_in_ready !== 1'b0) begin failed++; $display("FAIL bp_in_ready got %b want 0", b_in_ready); end
        tick();
        compared++; if (b_out_data !== 32'hCAFE_0011 || b_occ !== 2'd2) begin failed++; $display("FAIL bp_stable got %h occ=%0d", b_out_data, b_occ); end
        compared++; if (b_stall_cnt !== (PERF ? 4'd1 : 4'd0)) begin failed++; $display("FAIL bp_stall_cnt got %0d want %0d", b_stall_cnt, PERF ? 1 : 0); end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        tick();
        compared++; if (b_out_data !== 32'hBEEF_0022 || b_out_valid !== 1'b1 || b_occ !== 2'd1) begin failed++; $display("FAIL bp_second got %h v=%b occ=%0d", b_out_data, b_out_valid, b_occ); end
        tick();
        compared++; if (b_out_data !== 32'hD00D_0000 || b_out_valid !== 1'b0 || b_occ !== 2'd0) begin failed++; $display("FAIL bp_empty got %h v=%b occ=%0d", b_out_data, b_out_valid, b_occ); end
    endtask

    // 20 hold cycles on a 4-bit counter starting at 1.
    task automatic test_saturation();
        b_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 9) begin
                compared++; if (b_stall_cnt !== (PERF ? 4'd11 : 4'd0)) begin failed++; $display("FAIL sat_mid got %0d want %0d", b_stall_cnt, PERF ? 11 : 0); end
            end
        end
        b_hold = 1'b0;
        compared++; if (b_stall_cnt !== (PERF ? 4'd15 : 4'd0)) begin failed++; $display("FAIL sat_end got %0d want %0d", b_stall_cnt, PERF ? 15 : 0); end
    endtask

    initial begin
        a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = 32'h0; a_hold = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = 32'h0; b_hold = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        test_reset();
        test_pipeline();
        test_flush();
        test_hold();
        test_flush_hold_rst();
        test_backpressure();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
